// File: rtl/alu_control.sv
// Registered ALU operation decoder for load/store, branch, R-type and I-type arithmetic.
// Shift decoding is compiled in only when ALUCTL_SHIFT_EN is defined.
module alu_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] ALUControl,
    output logic       shift_arith,
    output logic       illegal,
    output logic       out_valid
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALUCTL_SHIFT_EN
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRX = 3'b111;
`endif

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [2:0] ctrl_next;
    logic       arith_next;
    logic       illegal_next;
    logic       ctrl_illegal;

    logic [2:0] ctrl_reg;
    logic       arith_reg;
    logic       illegal_reg;
    logic       valid_reg;

    logic       is_rtype;
    logic       f7_base;
    logic       f7_alt;

    assign is_rtype = (ALUOp == 2'b10);
    assign f7_base  = (funct7 == F7_BASE);
    assign f7_alt   = (funct7 == F7_ALT);

    // Raw decode; ctrl_illegal forces the canonical illegal output pattern below.
    always_comb begin
        ctrl_next    = OP_ADD;
        arith_next   = 1'b0;
        ctrl_illegal = 1'b0;
        unique case (ALUOp)
            2'b00: ctrl_next = OP_ADD;
            2'b01: ctrl_next = OP_SUB;
            default: begin
                unique case (funct3)
                    3'b000: begin
                        if (!is_rtype || f7_base) begin
                            ctrl_next = OP_ADD;
                        end else if (f7_alt) begin
                            ctrl_next = OP_SUB;
                        end else begin
                            ctrl_illegal = 1'b1;
                        end
                    end
                    3'b111: begin
                        ctrl_next    = OP_AND;
                        ctrl_illegal = is_rtype && !f7_base;
                    end
                    3'b110: begin
                        ctrl_next    = OP_OR;
                        ctrl_illegal = is_rtype && !f7_base;
                    end
                    3'b100: begin
                        ctrl_next    = OP_XOR;
                        ctrl_illegal = is_rtype && !f7_base;
                    end
                    3'b010: begin
                        ctrl_next    = OP_SLT;
                        ctrl_illegal = is_rtype && !f7_base;
                    end
`ifdef ALUCTL_SHIFT_EN
                    // Shift funct7 is checked for both R-type and I-type (imm[11:5]).
                    3'b001: begin
                        ctrl_next    = OP_SLL;
                        ctrl_illegal = !f7_base;
                    end
                    3'b101: begin
                        ctrl_next    = OP_SRX;
                        arith_next   = f7_alt;
                        ctrl_illegal = !(f7_base || f7_alt);
                    end
`endif
                    default: ctrl_illegal = 1'b1;
                endcase
            end
        endcase
    end

    logic [2:0] ctrl_final;
    logic       arith_final;

    always_comb begin
        ctrl_final   = ctrl_next;
        arith_final  = arith_next;
        illegal_next = 1'b0;
        if (ctrl_illegal) begin
            ctrl_final   = OP_ADD;
            arith_final  = 1'b0;
            illegal_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_reg    <= 3'b000;
            arith_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else if (in_valid) begin
            ctrl_reg    <= ctrl_final;
            arith_reg   <= arith_final;
            illegal_reg <= illegal_next;
            valid_reg   <= 1'b1;
        end else begin
            valid_reg   <= 1'b0;
        end
    end

    assign ALUControl  = ctrl_reg;
    assign shift_arith = arith_reg;
    assign illegal     = illegal_reg;
    assign out_valid   = valid_reg;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed steps followed by random steps
// compared against a rule-table reference model.
module tb_alu_control;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [2:0] ALUControl;
    logic       shift_arith;
    logic       illegal;
    logic       out_valid;

    int n_vec;
    int n_err;

    logic [2:0] exp_ctrl;
    logic       exp_arith;
    logic       exp_ill;
    logic       exp_ov;
    logic       primed;

    alu_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .funct7     (funct7),
        .ALUControl (ALUControl),
        .shift_arith(shift_arith),
        .illegal    (illegal),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALUCTL_SHIFT_EN
    localparam bit SHIFTS = 1'b1;
`else
    localparam bit SHIFTS = 1'b0;
`endif

    // Reference: result = {code, arith, illegal} from the instruction-level rules.
    function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7);
        int  code;
        bit  ok;
        bit  sra;
        bit  rtype;
        code  = 0;
        ok    = 1;
        sra   = 0;
        rtype = (op == 2);
        if (op == 0) begin
            code = 0;
        end else if (op == 1) begin
            code = 1;
        end else begin
            case (int'(f3))
                0: begin
                    if (!rtype)         code = 0;
                    else if (f7 == 0)   code = 0;
                    else if (f7 == 32)  code = 1;
                    else                ok = 0;
                end
                7: begin code = 2; ok = !rtype || f7 == 0; end
                6: begin code = 3; ok = !rtype || f7 == 0; end
                4: begin code = 4; ok = !rtype || f7 == 0; end
                2: begin code = 5; ok = !rtype || f7 == 0; end
                1: begin code = 6; ok = SHIFTS && f7 == 0; end
                5: begin code = 7; ok = SHIFTS && (f7 == 0 || f7 == 32); sra = (f7 == 32); end
                default: ok = 0;
            endcase
        end
        if (!ok) return 5'b000_0_1;
        return {code[2:0], sra, 1'b0};
    endfunction

    task automatic check_all(input string tag);
        n_vec++;
        assert (ALUControl === exp_ctrl) else begin
            n_err++;
            $error("FAIL %s ALUControl got %b want %b", tag, ALUControl, exp_ctrl);
        end
        n_vec++;
        assert (shift_arith === exp_arith) else begin
            n_err++;
            $error("FAIL %s shift_arith got %b want %b", tag, shift_arith, exp_arith);
        end
        n_vec++;
        assert (illegal === exp_ill) else begin
            n_err++;
            $error("FAIL %s illegal got %b want %b", tag, illegal, exp_ill);
        end
        n_vec++;
        assert (out_valid === exp_ov) else begin
            n_err++;
            $error("FAIL %s out_valid got %b want %b", tag, out_valid, exp_ov);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input string tag);
        logic [4:0] res;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        ALUOp    = op;
        funct3   = f3;
        funct7   = f7;
        #1;
        // Outputs must not react to input changes between edges.
        if (primed) check_all({tag, "_between"});
        @(posedge clk);
        if (!r) begin
            exp_ctrl = 3'b000; exp_arith = 1'b0; exp_ill = 1'b0; exp_ov = 1'b0;
        end else if (v) begin
            res = ref_decode(op, f3, f7);
            exp_ctrl = res[4:2]; exp_arith = res[1]; exp_ill = res[0]; exp_ov = 1'b1;
        end else begin
            exp_ov = 1'b0;
        end
        primed = 1'b1;
        #1;
        check_all(tag);
        $display("step %-10s rst_n=%b v=%b op=%b f3=%b f7=%b -> ctrl=%b arith=%b ill=%b ov=%b",
                 tag, r, v, op, f3, f7, ALUControl, shift_arith, illegal, out_valid);
    endtask

    initial begin
        logic [6:0] f7r;
        n_vec = 0; n_err = 0; primed = 1'b0;
        exp_ctrl = '0; exp_arith = 1'b0; exp_ill = 1'b0; exp_ov = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; ALUOp = '0; funct3 = '0; funct7 = '0;

        step(1'b0, 1'b0, 2'b00, 3'b000, 7'h00, "reset");
        step(1'b0, 1'b1, 2'b01, 3'b000, 7'h00, "rst_prio");
        step(1'b1, 1'b1, 2'b00, 3'b000, 7'h00, "ld_add");
        step(1'b1, 1'b1, 2'b01, 3'b000, 7'h00, "br_sub");
        step(1'b1, 1'b1, 2'b01, 3'b011, 7'h55, "br_ign");
        step(1'b1, 1'b1, 2'b10, 3'b000, 7'h00, "r_add");
        step(1'b1, 1'b1, 2'b10, 3'b000, 7'h20, "r_sub");
        step(1'b1, 1'b1, 2'b10, 3'b000, 7'h01, "r_add_bad");
        step(1'b1, 1'b1, 2'b10, 3'b111, 7'h00, "r_and");
        step(1'b1, 1'b1, 2'b10, 3'b110, 7'h00, "r_or");
        step(1'b1, 1'b1, 2'b10, 3'b100, 7'h00, "r_xor");
        step(1'b1, 1'b1, 2'b10, 3'b010, 7'h00, "r_slt");
        step(1'b1, 1'b1, 2'b10, 3'b011, 7'h00, "r_sltu");
        step(1'b1, 1'b1, 2'b10, 3'b111, 7'h20, "r_and_bad");
        step(1'b1, 1'b1, 2'b11, 3'b101, 7'h20, "i_sra");
        step(1'b1, 1'b1, 2'b10, 3'b101, 7'h00, "r_srl");
        step(1'b1, 1'b1, 2'b10, 3'b001, 7'h00, "r_sll");
        step(1'b1, 1'b1, 2'b11, 3'b001, 7'h20, "i_sll_bad");
        step(1'b1, 1'b1, 2'b11, 3'b011, 7'h00, "i_sltu");
        step(1'b1, 1'b1, 2'b11, 3'b000, 7'h55, "i_add");
        step(1'b1, 1'b1, 2'b11, 3'b111, 7'h7f, "i_and");
        step(1'b1, 1'b1, 2'b11, 3'b101, 7'h20, "i_sra2");
        step(1'b1, 1'b0, 2'b10, 3'b011, 7'h00, "hold1");
        step(1'b1, 1'b0, 2'b01, 3'b000, 7'h00, "hold2");
        step(1'b1, 1'b1, 2'b10, 3'b110, 7'h00, "r_or2");
        step(1'b0, 1'b1, 2'b10, 3'b100, 7'h00, "mid_rst");
        step(1'b1, 1'b1, 2'b10, 3'b000, 7'h20, "first_ok");

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       f7r = 7'h00;
                1:       f7r = 7'h20;
                default: f7r = 7'($urandom);
            endcase
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
                 2'($urandom), 3'($urandom), f7r, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
- REQ-001: clk  input  1  sole clock; all state updates on rising edge.
- REQ-002: rst_n  input  1  reset, synchronous and active-low.
- REQ-003: in_valid  input  1  decode request; ALUOp/funct3/funct7 sampled when high.
- REQ-004: ALUOp  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
- REQ-005: funct3  input  3  instruction funct3 field.
- REQ-006: funct7  input  7  instruction funct7 field (imm[11:5] for I-type).
- REQ-007: ALUControl  output  3  registered ALU operation code.
- REQ-008: shift_arith  output  1  registered; 1 selects arithmetic right shift.
- REQ-009: illegal  output  1  registered; 1 = unsupported encoding decoded.
- REQ-010: out_valid  output  1  registered; 1 = outputs hold a fresh decode.

Function
- REQ-011: Encoding: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL/SRA 111.
- REQ-012: ALUOp=00 -> ADD; ALUOp=01 -> SUB; funct3/funct7 ignored; illegal=0.
- REQ-013: ALUOp=10, funct3=000: funct7=0000000 -> ADD; funct7=0100000 -> SUB; any other funct7 -> illegal.
- REQ-014: ALUOp=11, funct3=000 -> ADD regardless of funct7.
- REQ-015: ALUOp=10 or 11: funct3 111 -> AND, 110 -> OR, 100 -> XOR, 010 -> SLT; funct7 checked only for ALUOp=10 (must be 0000000, else illegal).
- REQ-016: funct3=011 (SLTU) -> illegal for all ALUOp=10/11.
- REQ-017: Shifts (ALUOp=10/11, funct3 001/101) per REQ-027/028.
- REQ-018: Illegal decode: ALUControl=000, shift_arith=0, illegal=1.
- REQ-019: shift_arith=0 for every non-SRA decode.
- REQ-020: Latency exactly 1 cycle: decode of inputs sampled at edge N with in_valid=1 appears at outputs after edge N, out_valid=1.
- REQ-021: in_valid=0 at an edge: ALUControl/shift_arith/illegal hold previous values; out_valid=0.
- REQ-022: Back-to-back in_valid=1 each cycle yields one result per cycle, no bubbles.
- REQ-023: No combinational path from inputs to outputs.

Reset
- REQ-024: rst_n=0 at a rising edge: ALUControl=000, shift_arith=0, illegal=0, out_valid=0.
- REQ-025: Reset has priority over in_valid; a request sampled on a reset edge is discarded.
- REQ-026: First decode accepted on first edge with rst_n=1 and in_valid=1.

Configuration
- REQ-027: Macro ALUCTL_SHIFT_EN defined: funct3=001 with funct7=0000000 -> SLL (110); funct3=101 with funct7=0000000 -> SRL (111, shift_arith=0); funct3=101 with funct7=0100000 -> SRA (111, shift_arith=1); other funct7 with 001/101 -> illegal (applies to ALUOp 10 and 11).
- REQ-028: Macro undefined: funct3 001/101 under ALUOp 10/11 -> illegal; shift_arith tied 0; encodings 110/111 never produced.

Verification
- REQ-029: Reset: rst_n=0 one edge -> ALUControl=000, illegal=0, out_valid=0.
- REQ-030: ALUOp=00, funct3=000, funct7=0000000, in_valid=1 -> next cycle ALUControl=000, out_valid=1; ALUOp=01 -> 001.
- REQ-031: ALUOp=10, funct3=000, funct7=0000000 -> 000; funct7=0100000 -> 001; funct7=0000001 -> illegal=1, ALUControl=000.
- REQ-032: ALUOp=10 funct3 111/110/100/010 funct7=0 -> 010/011/100/101 on consecutive cycles; funct3=011 -> illegal=1.
- REQ-033: With ALUCTL_SHIFT_EN: ALUOp=11 funct3=101 funct7=0100000 -> ALUControl=111, shift_arith=1; without macro -> illegal=1.
- REQ-034: in_valid dropped after a decode -> outputs hold, out_valid=0; rst_n=0 mid-stream -> all outputs zero next edge.
